adder_arbiter: RTL
==================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: operand and sum width in bits, legal range 1..16.
REQ-002 Parameter SETTLE, default 3: cycles allowed for the ripple carry to settle, legal range 1..15.
REQ-003 The port list SHALL be exactly as follows (one clock; reset is asynchronous and active-high).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_cin  in  1  requester 0 carry-in
- req0_ready  out  1  requester 0 operation accepted this cycle
- req1_valid, req1_a, req1_b, req1_cin, req1_ready: same as requester 0, for requester 1
- add_a, add_b  out  WIDTH  registered operands driven to the shared combinational adder
- add_cin  out  1  registered carry-in to the shared adder
- add_sum  in  WIDTH  shared adder sum
- add_cout  in  1  shared adder carry-out
- rsp_valid  out  1  result available
- rsp_id  out  1  requester that owns the result
- rsp_sum  out  WIDTH  captured sum
- rsp_cout  out  1  captured carry-out
- rsp_ready  in  1  consumer takes the result

Function
REQ-004 FSM states: IDLE, SETTLE, RESP; only one operation is in flight at a time.
REQ-005 IDLE, no valid request: stay in IDLE; both reqN_ready = 0.
REQ-006 IDLE, exactly one reqN_valid: reqN_ready = 1 combinationally in that cycle; that cycle is the accept cycle.
REQ-007 IDLE, both valid: the requester named by priority pointer ptr gets ready = 1; the other gets 0.
REQ-008 At the accept edge: register reqN_a/b/cin into add_a/b/cin; set rsp_id = N; load the settle counter; go to SETTLE.
REQ-009 SETTLE: add_a/b/cin SHALL stay stable; at the SETTLE-th rising edge after the accept edge, capture add_sum and add_cout into rsp_sum and rsp_cout, set rsp_valid = 1, and go to RESP.
REQ-010 RESP: hold rsp_valid, rsp_id, rsp_sum and rsp_cout stable until rsp_valid and rsp_ready are both 1 at a rising edge.
REQ-011 On that edge: rsp_valid = 0; ptr = ~rsp_id; go to IDLE. No new accept occurs in the same cycle (one idle cycle between operations).
REQ-012 reqN_ready SHALL be 0 in SETTLE and RESP, whatever the valid inputs are.
REQ-013 rsp_ready is ignored outside RESP.
REQ-014 Requester inputs may change at any time except during the accept cycle; values outside the accept cycle have no effect.
REQ-015 Arithmetic is performed only by the external adder; the block adds no width extension, and any carry beyond WIDTH appears only on add_cout/rsp_cout.

Reset
REQ-016 While rst = 1, asynchronously: state = IDLE; ptr = 0; counter = 0; add_a = add_b = 0; add_cin = 0; rsp_valid = 0; rsp_id = 0; rsp_sum = 0; rsp_cout = 0; req0_ready = req1_ready = 0.
REQ-017 Reset asserted in SETTLE or RESP abandons the operation with no response.
REQ-018 The first accept can occur in the first cycle after rst deasserts.

Configuration
REQ-019 Macro ADDER_ARBITER_OVF_EN, when defined, adds output port rsp_ovf (1 bit). It SHALL be captured with rsp_sum as signed overflow: add_a[MSB] == add_b[MSB] and add_sum[MSB] != add_a[MSB]. Reset value 0; held like rsp_sum.
REQ-020 Without ADDER_ARBITER_OVF_EN, port rsp_ovf and its logic SHALL be absent; all other behaviour is identical.

Verification (WIDTH=4, SETTLE=3, external adder is a 4-bit ripple adder)
REQ-021 Single request: rst released; req0 a=3, b=4, cin=0, rsp_ready=1. Required: req0_ready=1 for one cycle; rsp_valid rises 3 edges after the accept edge with rsp_id=0, rsp_sum=7, rsp_cout=0.
REQ-022 Carry-out: req1 a=15, b=1, cin=0. Required: rsp_id=1, rsp_sum=0, rsp_cout=1; with ADDER_ARBITER_OVF_EN, rsp_ovf=0.
REQ-023 Round-robin: both requesters valid continuously (req0 1+2, req1 5+5+cin 1). Required grant order 0,1,0,1 with sums 3,11,3,11; never two consecutive grants to the same requester.
REQ-024 Backpressure: rsp_ready=0 for 10 cycles after rsp_valid. Required: rsp_* held stable, both ready=0 throughout; the next accept occurs only after the cycle following rsp_ready=1.
REQ-025 Reset mid-operation: rst pulsed for 1 cycle in SETTLE after accepting req0 (7+8). Required: no rsp_valid; ptr=0; the next request (req1 2+2) returns rsp_sum=4, rsp_id=1.
REQ-026 Overflow (ADDER_ARBITER_OVF_EN defined): a=7, b=1, cin=0. Required: rsp_sum=8, rsp_cout=0, rsp_ovf=1.

Source files
------------

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - two-requester round-robin front end for a shared external ripple adder
// Optional rsp_ovf output (signed overflow) enabled by defining ADDER_ARBITER_OVF_EN.
module adder_arbiter #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             req1_ready,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
`ifdef ADDER_ARBITER_OVF_EN
    output logic             rsp_ovf,
`endif
    input  logic             rsp_ready
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;

    state_t     state;
    logic       ptr;
    logic [3:0] cnt;
    logic       gnt0;
    logic       gnt1;

    // Grants are combinational so the accept happens in the same cycle valid is seen.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && state == S_IDLE) begin
            if (req0_valid && (!req1_valid || !ptr))
                gnt0 = 1'b1;
            else if (req1_valid)
                gnt1 = 1'b1;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= 1'b0;
            cnt       <= 4'd0;
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
`ifdef ADDER_ARBITER_OVF_EN
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt0 || gnt1) begin
                        add_a   <= gnt1 ? req1_a   : req0_a;
                        add_b   <= gnt1 ? req1_b   : req0_b;
                        add_cin <= gnt1 ? req1_cin : req0_cin;
                        rsp_id  <= gnt1;
                        cnt     <= 4'(SETTLE - 1);
                        state   <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    // Counter reaches zero on the SETTLE-th edge after accept.
                    if (cnt == 4'd0) begin
                        rsp_sum   <= add_sum;
                        rsp_cout  <= add_cout;
`ifdef ADDER_ARBITER_OVF_EN
                        rsp_ovf   <= (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                                     (add_sum[WIDTH-1] != add_a[WIDTH-1]);
`endif
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= ~rsp_id;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
